alu_flags_wb: RTL

- Writeback/flag-commit stage directly downstream of the ALU. It consumes the ALU result, the NZVC flags and the decoded instruction fields.
- It owns the architectural NZVC flag register and evaluates the 4-bit ARM condition field against it. It commits flags for flag-setting instructions and queues register writes in a 2-entry buffer toward the register file.
- The committed carry (flags[0]) is fed back to the ALU carry input.

---
 rtl/alu_flags_wb.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_flags_wb.sv
// -----------------------------------------------------------------------------
// alu_flags_wb
//   Writeback / flag-commit stage that sits directly after the ALU.
//   - Holds the architectural NZVC flag register. The carry bit (flags[0]) is
//     fed back to the ALU carry input.
//   - Evaluates the ARM condition field of each incoming instruction against
//     the flags as they were before that instruction.
//   - Commits in_nzvc for passing flag-setting instructions.
//   - Queues passing register writes in a DEPTH-entry FIFO toward the
//     register file.
//   - Counts executed (condition pass) and skipped (condition fail)
//     instructions. Both counters saturate at all-ones.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous buffer flush; flags are never rolled back
//   in_valid/in_ready   ALU result handshake (in_ready = buffer not full)
//   in_result/in_nzvc   ALU result and {N,Z,V,C}
//   in_rd/in_cond       destination index and ARM condition field
//   in_setflags/in_wr_en  S-bit and register-write enable
//   out_valid/out_ready writeback handshake toward the register file
//   out_rd/out_data     head buffer entry
//   flags               committed NZVC
//   exec_cnt/skip_cnt   statistics counters
// -----------------------------------------------------------------------------
module alu_flags_wb #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic [3:0]       in_nzvc,
    input  logic [3:0]       in_rd,
    input  logic [3:0]       in_cond,
    input  logic             in_setflags,
    input  logic             in_wr_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rd,
    output logic [31:0]      out_data,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    // ARM condition check; flag vector is {N,Z,V,C}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzvc);
        logic n, z, v, c;
        n = nzvc[3];
        z = nzvc[2];
        v = nzvc[1];
        c = nzvc[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [35:0]      r_mem [DEPTH];

    logic             w_full;
    logic             w_accept;
    logic             w_pass;
    logic             w_enq;
    logic             w_deq;
    logic [PTR_W:0]   w_count_nxt;

    assign w_full    = (r_count == COUNT_FULL);
    assign in_ready  = !w_full;
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid && in_ready;
    assign w_pass    = cond_pass(in_cond, r_flags);
    assign w_enq     = w_accept && w_pass && in_wr_en;
    assign w_deq     = out_valid && out_ready;

    assign flags     = r_flags;
    assign exec_cnt  = r_exec_cnt;
    assign skip_cnt  = r_skip_cnt;
    assign out_rd    = r_mem[r_rptr][35:32];
    assign out_data  = r_mem[r_rptr][31:0];

    // Next occupancy: simultaneous enqueue and dequeue leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flag register and saturating statistics counters; flush never touches them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags    <= 4'b0000;
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else if (w_accept) begin
            if (w_pass) begin
                if (in_setflags) begin
                    r_flags <= in_nzvc;
                end
                if (r_exec_cnt != '1) begin
                    r_exec_cnt <= r_exec_cnt + CNT_W'(1);
                end
            end else if (r_skip_cnt != '1) begin
                r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
        end
    end

    // Buffer pointers and occupancy; flush wins over enqueue and dequeue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else if (flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_enq) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Buffer storage; cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 36'd0;
            end
        end else if (w_enq && !flush) begin
            r_mem[r_wptr] <= {in_rd, in_result};
        end
    end

endmodule
